// File: rtl/reg_file_sb_if.sv
// rtl/reg_file_sb_if.sv - write, read, issue and status signals of the register file
interface reg_file_sb_if #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_READ = 2
);
    logic                         we;
    logic [ADDR_W-1:0]            Rd;
    logic [DATA_W-1:0]            data_in;
    logic [1:0]                   wr_size;
    logic                         wr_unsigned;
    logic [NUM_READ*ADDR_W-1:0]   Rs;
    logic [NUM_READ*DATA_W-1:0]   read_data;
    logic [NUM_READ-1:0]          rs_ready;
    logic                         issue_valid;
    logic [ADDR_W-1:0]            issue_rd;
    logic [ADDR_W:0]              pend_count;

    modport master (
        output we, Rd, data_in, wr_size, wr_unsigned, Rs, issue_valid, issue_rd,
        input  read_data, rs_ready, pend_count
    );

    modport slave (
        input  we, Rd, data_in, wr_size, wr_unsigned, Rs, issue_valid, issue_rd,
        output read_data, rs_ready, pend_count
    );
endinterface

// File: rtl/reg_file_sb.sv
// rtl/reg_file_sb.sv - multi-port register file with load extension, bypass and pending scoreboard
module reg_file_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_READ = 2,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic          clk,
    input  logic          rst,
    reg_file_sb_if.slave  bus
);
    localparam int DEPTH = 2**ADDR_W;

    logic [DATA_W-1:0] regs [DEPTH];
    logic [DEPTH-1:0]  pending;
    logic [ADDR_W:0]   pend_cnt;
    logic [DATA_W-1:0] wdata_ext;
    logic              wr_ok;
    logic              set_ok;
    logic              inc;
    logic              dec;
    logic [DATA_W-1:0] rdata [NUM_READ];
    logic              rdy   [NUM_READ];

    always_comb begin
        wdata_ext = bus.data_in;
        case (bus.wr_size)
            2'b00:   wdata_ext = {{(DATA_W-8){~bus.wr_unsigned & bus.data_in[7]}}, bus.data_in[7:0]};
            2'b01:   wdata_ext = {{(DATA_W-16){~bus.wr_unsigned & bus.data_in[15]}}, bus.data_in[15:0]};
            default: wdata_ext = bus.data_in;
        endcase
    end

    assign wr_ok  = bus.we && !((ZERO_REG != 0) && (bus.Rd == '0));
    assign set_ok = bus.issue_valid && !((ZERO_REG != 0) && (bus.issue_rd == '0));

    // Count moves only when a bit actually flips; a same-register set+clear leaves the bit set.
    assign inc = set_ok && !pending[bus.issue_rd];
    assign dec = wr_ok && pending[bus.Rd] && !(set_ok && (bus.issue_rd == bus.Rd));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_ok) begin
            regs[bus.Rd] <= wdata_ext;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending  <= '0;
            pend_cnt <= '0;
        end else begin
            if (wr_ok) begin
                pending[bus.Rd] <= 1'b0;
            end
            if (set_ok) begin
                pending[bus.issue_rd] <= 1'b1;
            end
            if (inc && !dec) begin
                pend_cnt <= pend_cnt + (ADDR_W+1)'(1);
            end else if (dec && !inc) begin
                pend_cnt <= pend_cnt - (ADDR_W+1)'(1);
            end
        end
    end

    for (genvar g = 0; g < NUM_READ; g++) begin : g_read
        logic [ADDR_W-1:0] rs;
        logic              byp;
        logic              is_zero;

        assign rs      = bus.Rs[g*ADDR_W +: ADDR_W];
        // Forwarding is suppressed during reset so reads stay zero while rst is high.
        assign byp     = (BYPASS != 0) && !rst && wr_ok && (bus.Rd == rs);
        assign is_zero = (ZERO_REG != 0) && (rs == '0);
        assign rdata[g] = is_zero ? '0 : (byp ? wdata_ext : regs[rs]);
        assign rdy[g]   = is_zero || byp || !pending[rs];
    end

    always_comb begin
        bus.read_data = '0;
        bus.rs_ready  = '0;
        for (int i = 0; i < NUM_READ; i++) begin
            bus.read_data[i*DATA_W +: DATA_W] = rdata[i];
            bus.rs_ready[i]                   = rdy[i];
        end
    end

    assign bus.pend_count = pend_cnt;
endmodule

// File: tb/tb_reg_file_sb.sv
// tb/tb_reg_file_sb.sv - scoreboard bench for reg_file_sb with and without bypass
module tb_reg_file_sb;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    reg_file_sb_if #(.DATA_W(32), .ADDR_W(5), .NUM_READ(2)) bus ();
    reg_file_sb_if #(.DATA_W(32), .ADDR_W(5), .NUM_READ(2)) bus_nb ();

    assign bus_nb.we          = bus.we;
    assign bus_nb.Rd          = bus.Rd;
    assign bus_nb.data_in     = bus.data_in;
    assign bus_nb.wr_size     = bus.wr_size;
    assign bus_nb.wr_unsigned = bus.wr_unsigned;
    assign bus_nb.Rs          = bus.Rs;
    assign bus_nb.issue_valid = bus.issue_valid;
    assign bus_nb.issue_rd    = bus.issue_rd;

    reg_file_sb #(.DATA_W(32), .ADDR_W(5), .NUM_READ(2), .BYPASS(1), .ZERO_REG(1)) dut_byp (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    reg_file_sb #(.DATA_W(32), .ADDR_W(5), .NUM_READ(2), .BYPASS(0), .ZERO_REG(1)) dut_nb (
        .clk (clk),
        .rst (rst),
        .bus (bus_nb.slave)
    );

    typedef struct {
        logic [63:0] rd_b;
        logic [63:0] rd_nb;
        logic [1:0]  rdy_b;
        logic [1:0]  rdy_nb;
        logic [5:0]  cnt;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] m_mem  [32];
    logic        m_pend [32];
    int          m_cnt;
    int          total  = 0;
    int          passed = 0;

    function automatic logic [31:0] m_ext(input logic [31:0] d, input logic [1:0] sz, input logic u);
        logic [7:0]  b;
        logic [15:0] h;
        b = d[7:0];
        h = d[15:0];
        if (sz == 2'b00) return u ? 32'(b) : 32'($signed(b));
        if (sz == 2'b01) return u ? 32'(h) : 32'($signed(h));
        return d;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_mem[i]  = '0;
            m_pend[i] = 1'b0;
        end
        m_cnt = 0;
    endtask

    task automatic commit();
        if (!rst) begin
            if (bus.we && bus.Rd != 0) begin
                m_mem[bus.Rd]  = m_ext(bus.data_in, bus.wr_size, bus.wr_unsigned);
                m_pend[bus.Rd] = 1'b0;
            end
            if (bus.issue_valid && bus.issue_rd != 0) m_pend[bus.issue_rd] = 1'b1;
            m_cnt = 0;
            for (int i = 0; i < 32; i++) m_cnt += int'(m_pend[i]);
        end
    endtask

    task automatic push_expect();
        exp_t        e;
        logic [4:0]  rs;
        logic        byp;
        logic [31:0] ext;
        ext = m_ext(bus.data_in, bus.wr_size, bus.wr_unsigned);
        for (int i = 0; i < 2; i++) begin
            rs  = (i == 0) ? bus.Rs[4:0] : bus.Rs[9:5];
            byp = !rst && bus.we && (bus.Rd == rs) && (rs != 0);
            e.rd_b[i*32 +: 32]  = (rs == 0) ? 32'h0 : (byp ? ext : m_mem[rs]);
            e.rd_nb[i*32 +: 32] = (rs == 0) ? 32'h0 : m_mem[rs];
            e.rdy_b[i]          = (rs == 0) || byp || !m_pend[rs];
            e.rdy_nb[i]         = (rs == 0) || !m_pend[rs];
        end
        e.cnt = 6'(m_cnt);
        exp_q.push_back(e);
    endtask

    task automatic drive(input logic w, input logic [4:0] rd, input logic [31:0] d,
                         input logic [1:0] sz, input logic u, input logic [4:0] r0,
                         input logic [4:0] r1, input logic iv, input logic [4:0] ir);
        bus.we          = w;
        bus.Rd          = rd;
        bus.data_in     = d;
        bus.wr_size     = sz;
        bus.wr_unsigned = u;
        bus.Rs          = {r1, r0};
        bus.issue_valid = iv;
        bus.issue_rd    = ir;
    endtask

    task automatic step(input logic w, input logic [4:0] rd, input logic [31:0] d,
                        input logic [1:0] sz, input logic u, input logic [4:0] r0,
                        input logic [4:0] r1, input logic iv, input logic [4:0] ir);
        @(posedge clk);
        #1;
        commit();
        rst = 1'b0;
        drive(w, rd, d, sz, u, r0, r1, iv, ir);
        push_expect();
    endtask

    task automatic reset_mid();
        @(posedge clk);
        #1;
        commit();
        rst = 1'b1;
        model_reset();
        push_expect();
    endtask

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got === want) passed++;
        else $display("FAIL %s at %0t: got %h want %h", name, $time, got, want);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("read_data_byp", bus.read_data, e.rd_b);
                check("read_data_nb",  bus_nb.read_data, e.rd_nb);
                check("rs_ready_byp",  64'(bus.rs_ready), 64'(e.rdy_b));
                check("rs_ready_nb",   64'(bus_nb.rs_ready), 64'(e.rdy_nb));
                check("pend_count",    64'(bus.pend_count), 64'(e.cnt));
                check("pend_count_nb", 64'(bus_nb.pend_count), 64'(e.cnt));
            end
        end
    end

    initial begin
        rst = 1'b1;
        drive(1'b0, 5'd0, 32'h0, 2'b10, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0);
        model_reset();
        @(posedge clk);
        #1;
        push_expect();

        // Write r5 and issue r6, then reset mid-cycle with the write still asserted.
        step(1, 5, 32'hDEADBEEF, 2'b10, 0, 5, 6, 1, 6);
        reset_mid();
        step(0, 0, 0, 2'b10, 0, 5, 6, 0, 0);

        // Load extension.
        step(1, 3, 32'h0000_0080, 2'b00, 0, 3, 0, 0, 0);
        step(0, 0, 0, 2'b10, 0, 3, 0, 0, 0);
        step(1, 3, 32'h0000_0080, 2'b00, 1, 3, 0, 0, 0);
        step(0, 0, 0, 2'b10, 0, 3, 0, 0, 0);
        step(1, 3, 32'h0000_8001, 2'b01, 0, 3, 0, 0, 0);
        step(0, 0, 0, 2'b10, 0, 3, 0, 0, 0);
        step(1, 3, 32'hFFFF_8001, 2'b01, 1, 3, 0, 0, 0);

        // Register 0 ignores writes and issues.
        step(1, 0, 32'h1234, 2'b10, 0, 0, 0, 0, 0);
        step(0, 0, 0, 2'b10, 0, 0, 0, 1, 0);
        step(0, 0, 0, 2'b10, 0, 0, 0, 0, 0);

        // Same-cycle forward versus next-cycle visibility.
        step(1, 7, 32'hA5A5_A5A5, 2'b10, 0, 7, 7, 0, 0);
        step(0, 0, 0, 2'b10, 0, 7, 7, 0, 0);

        // Scoreboard set/clear.
        step(0, 0, 0, 2'b10, 0, 9, 10, 1, 9);
        step(0, 0, 0, 2'b10, 0, 9, 10, 0, 0);
        step(1, 9, 32'h99, 2'b10, 0, 9, 10, 1, 10);
        step(0, 0, 0, 2'b10, 0, 9, 10, 0, 0);
        step(1, 10, 32'h1010, 2'b10, 0, 9, 10, 0, 0);
        step(0, 0, 0, 2'b10, 0, 9, 10, 0, 0);

        // Same-register issue and write: set wins, data still stored.
        step(1, 4, 32'h55, 2'b10, 0, 4, 0, 1, 4);
        step(0, 0, 0, 2'b10, 0, 4, 0, 0, 0);
        step(1, 4, 32'h66, 2'b10, 0, 4, 0, 0, 0);
        step(0, 0, 0, 2'b10, 0, 4, 0, 0, 0);

        for (int n = 0; n < 400; n++) begin
            logic [4:0] rd;
            logic [4:0] r0;
            rd = 5'($urandom_range(0, 31));
            r0 = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, 31));
            step(1'($urandom_range(0, 1)), rd, $urandom, 2'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), r0, 5'($urandom_range(0, 31)),
                 1'($urandom_range(0, 2) != 0), 5'($urandom_range(0, 31)));
            if (n == 200) begin
                reset_mid();
            end
        end

        for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(negedge clk);
        #1;
        total++;
        if (exp_q.size() == 0) passed++;
        else $display("FAIL drain: got %0d pending expectations want 0", exp_q.size());

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/reg_file_sb.md
# reg_file_sb

Parametrised multi-port register file for the single- and multi-cycle RISC-V cores. It generalises the 32×32 two-read-port file in four ways:
- configurable width, depth and read-port count;
- load-size extension (byte/half/word, signed/unsigned) applied on write;
- optional same-cycle write-to-read bypass;
- a per-register pending scoreboard with a live pending counter, so multi-cycle control can stall on outstanding writebacks.

## Interface
Parameters:
- DATA_W, 32, register width in bits (≥16).
- ADDR_W, 5, address width; depth = 2**ADDR_W.
- NUM_READ, 2, number of read ports (1–4).
- BYPASS, 1, 1 = write data forwarded combinationally to matching read ports.
- ZERO_REG, 1, 1 = register 0 hardwired to zero, never written, never pending.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- we  in  1  write enable.
- Rd  in  ADDR_W  write address.
- data_in  in  DATA_W  write data, before extension.
- wr_size  in  2  00 byte, 01 half, 10/11 full word.
- wr_unsigned  in  1  1 = zero-extend, 0 = sign-extend (ignored for word).
- Rs  in  NUM_READ*ADDR_W  read addresses; port i is at [i*ADDR_W +: ADDR_W].
- read_data  out  NUM_READ*DATA_W  read data; port i is at [i*DATA_W +: DATA_W].
- rs_ready  out  NUM_READ  port i: operand not pending, or bypassed this cycle.
- issue_valid  in  1  mark issue_rd as awaiting writeback.
- issue_rd  in  ADDR_W  destination being issued.
- pend_count  out  ADDR_W+1  number of registers currently pending.

## Operation
- Extension produces wdata_ext from data_in:
  - byte: bits [7:0] extended to DATA_W;
  - half: bits [15:0] extended to DATA_W;
  - word: data_in unchanged.
  - Extension is by sign (data_in[7] or data_in[15]) or by zero, per wr_unsigned.
- Write: at a rising edge with we=1, reg[Rd] ← wdata_ext. With ZERO_REG=1 a write to Rd=0 is dropped.
- Read is combinational for each port i:
  - Rs_i=0 with ZERO_REG=1 → 0;
  - else BYPASS=1, we=1 and Rd==Rs_i (and Rd≠0 when ZERO_REG=1) → wdata_ext;
  - else reg[Rs_i].
- Scoreboard: one pending bit per register, evaluated at each rising edge.
  - Set when issue_valid=1 (issue_rd≠0 when ZERO_REG=1).
  - Cleared when a write to the same register occurs (we=1).
  - Same register issued and written in the same edge → set wins; the write data is still stored.
  - Issue to an already-pending register → remains pending.
  - Write to a non-pending register → stored; pending stays 0.
- rs_ready[i] = !pending[Rs_i], or the bypass condition for port i holds. Register 0 is always ready when ZERO_REG=1.
- pend_count is registered and always equals the popcount of the pending bits. It updates by +1, −1 or 0 per edge, derived from the set and clear events above:
  - simultaneous set of A and clear of B (A≠B) → net 0;
  - set and clear of the same pending register → net 0;
  - set and clear of the same non-pending register → +1.

## Timing
- Reset (asynchronous, any time, including mid-write):
  - every register → 0 and every pending bit → 0;
  - pend_count → 0, rs_ready → all 1;
  - read_data → 0 for every address while rst is high and after release;
  - a write coincident with the reset edge is lost.
- Write-to-read latency:
  - 0 cycles with BYPASS=1 (same-cycle forward);
  - 1 cycle with BYPASS=0 (visible after the edge).
- Issue-to-stall latency is 1 cycle: pending is visible on rs_ready the cycle after issue_valid.
- No handshake back-pressure: every issue and write is accepted on its edge.
- pend_count cannot exceed depth−1 (ZERO_REG=1) or depth.

## Test plan
- Reset: write 0xDEADBEEF to r5, then assert rst mid-cycle → read_data for r5 = 0 immediately; pend_count=0; rs_ready all 1.
- Extension: write data_in=0x0000_0080 to r3 with wr_size=00, wr_unsigned=0 → r3=0xFFFF_FF80. Repeat with wr_unsigned=1 → 0x0000_0080. Half 0x8001, signed → 0xFFFF_8001.
- r0: we=1, Rd=0, data_in=0x1234 → Rs=0 reads 0. issue_valid to r0 → pend_count stays 0.
- Bypass: BYPASS=1; write 0xA5A5_A5A5 to r7 with Rs port0=7 in the same cycle → read_data port0 = 0xA5A5_A5A5 that cycle. With BYPASS=0 → old value, new value on the next cycle.
- Scoreboard:
  - issue r9 → rs_ready for Rs=9 is 0 next cycle, pend_count=1;
  - issue r10 while writing r9 → pend_count stays 1, r9 ready;
  - write r10 → pend_count=0.
- Same-register collision: with r4 not pending, issue r4 and write r4=0x55 in the same cycle → r4 stores 0x55, stays pending, pend_count=1. A second write to r4 → pend_count=0.
